// File: rtl/iq_upconv.sv
// rtl/iq_upconv.sv - quadrature upconverter: s = I*cos - Q*sin, rounded and saturated
//
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_ce                  sample-rate enable; nothing advances while low
//   i_valid / o_ready     input handshake (o_ready is combinational: i_ce & (~o_valid | i_ready))
//   i_sig_i, i_sig_q      signed baseband I/Q, IW bits
//   i_lo_i, i_lo_q        signed LO cos/sin, sine_lookup_width bits
//   o_valid / i_ready     output handshake
//   o_signal, o_sat       real output sample and its saturation flag
//   i_sat_clr             synchronous clear of o_sat_count (wins over increment)
//   o_sat_count           saturating count of delivered saturated samples
module iq_upconv #(
    parameter int IW                = 16,
    parameter int sine_lookup_width = 16,
    parameter int CW                = 16
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_ce,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic signed [IW-1:0]                i_sig_i,
    input  logic signed [IW-1:0]                i_sig_q,
    input  logic signed [sine_lookup_width-1:0] i_lo_i,
    input  logic signed [sine_lookup_width-1:0] i_lo_q,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic signed [IW-1:0]                o_signal,
    output logic                                o_sat,
    input  logic                                i_sat_clr,
    output logic [CW-1:0]                       o_sat_count
);

    localparam int LW = sine_lookup_width;
    localparam int PW = IW + LW;       // product width
    localparam int DW = PW + 1;        // difference width

    // Half an output LSB, added before the arithmetic shift for round-half-up.
    localparam logic signed [DW-1:0] RND     = {{(DW-LW+1){1'b0}}, 1'b1, {(LW-2){1'b0}}};
    localparam logic signed [DW-1:0] SAT_MAX = {{(DW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN = {{(DW-IW+1){1'b1}}, {(IW-1){1'b0}}};
    localparam logic [CW-1:0]        CNT_MAX = '1;

    logic adv;

    // Stage 1: captured operands
    logic                 v1;
    logic signed [IW-1:0] s1_i, s1_q;
    logic signed [LW-1:0] s1_cos, s1_sin;

    // Stage 2: products
    logic                 v2;
    logic signed [PW-1:0] p_i, p_q;

    // Operands sign-extended to the product width so the multiply is full precision.
    logic signed [PW-1:0] m_i_a, m_i_b, m_q_a, m_q_b;

    // Stage 3 combinational combine/round/saturate
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] r;
    logic signed [IW-1:0] sat_val;
    logic                 sat_flag;

    // The whole pipeline moves as one; a held output blocks every stage.
    assign adv     = i_ce & (~o_valid | i_ready);
    assign o_ready = adv;

    assign m_i_a = {{LW{s1_i[IW-1]}}, s1_i};
    assign m_i_b = {{IW{s1_cos[LW-1]}}, s1_cos};
    assign m_q_a = {{LW{s1_q[IW-1]}}, s1_q};
    assign m_q_b = {{IW{s1_sin[LW-1]}}, s1_sin};

    assign d = {p_i[PW-1], p_i} - {p_q[PW-1], p_q};
    assign r = (d + RND) >>> (LW - 1);

    always_comb begin
        sat_val  = r[IW-1:0];
        sat_flag = 1'b0;
        if (r > SAT_MAX) begin
            sat_val  = SAT_MAX[IW-1:0];
            sat_flag = 1'b1;
        end else if (r < SAT_MIN) begin
            sat_val  = SAT_MIN[IW-1:0];
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            v1     <= 1'b0;
            s1_i   <= '0;
            s1_q   <= '0;
            s1_cos <= '0;
            s1_sin <= '0;
            v2     <= 1'b0;
            p_i    <= '0;
            p_q    <= '0;
        end else if (adv) begin
            v1     <= i_valid;
            s1_i   <= i_sig_i;
            s1_q   <= i_sig_q;
            s1_cos <= i_lo_i;
            s1_sin <= i_lo_q;
            v2     <= v1;
            p_i    <= m_i_a * m_i_b;
            p_q    <= m_q_a * m_q_b;
        end
    end

    // Output register: data only updates for a real sample so bubbles leave
    // the last delivered value on o_signal/o_sat.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid  <= 1'b0;
            o_signal <= '0;
            o_sat    <= 1'b0;
        end else if (adv) begin
            o_valid <= v2;
            if (v2) begin
                o_signal <= sat_val;
                o_sat    <= sat_flag;
            end
        end
    end

    // Counts on delivery, not on generation, so a stalled sample counts once.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sat_count <= '0;
        end else if (i_sat_clr) begin
            o_sat_count <= '0;
        end else if (o_valid && i_ready && i_ce && o_sat && (o_sat_count != CNT_MAX)) begin
            o_sat_count <= o_sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_iq_upconv.sv
// tb/tb_iq_upconv.sv - scoreboard bench for iq_upconv
module tb_iq_upconv;

    logic               i_clk;
    logic               i_reset_n;
    logic               i_ce;
    logic               i_valid;
    logic               o_ready;
    logic signed [15:0] i_sig_i, i_sig_q, i_lo_i, i_lo_q;
    logic               o_valid;
    logic               i_ready;
    logic signed [15:0] o_signal;
    logic               o_sat;
    logic               i_sat_clr;
    logic [15:0]        o_sat_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int ce_div = 1;
    int ce_cnt = 0;

    int exp_sig_q[$];
    bit exp_sat_q[$];

    iq_upconv #(.IW(16), .sine_lookup_width(16), .CW(16)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_ce        (i_ce),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sig_i     (i_sig_i),
        .i_sig_q     (i_sig_q),
        .i_lo_i      (i_lo_i),
        .i_lo_q      (i_lo_q),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_signal    (o_signal),
        .o_sat       (o_sat),
        .i_sat_clr   (i_sat_clr),
        .o_sat_count (o_sat_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Sample strobe: high one cycle in every ce_div, changed just after the edge.
    initial begin
        i_ce = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            ce_cnt++;
            i_ce = ((ce_cnt % ce_div) == 0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    // Monitor: pops one expectation per delivered sample.
    always @(negedge i_clk) begin
        if (i_reset_n && o_valid && i_ready && i_ce) begin
            if (exp_sig_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got %0d, expected no sample", o_signal);
            end else begin
                int e;
                bit es;
                e  = exp_sig_q.pop_front();
                es = exp_sat_q.pop_front();
                check("out_signal", o_signal, e);
                check("out_sat", o_sat, es);
            end
        end
    end

    task automatic send(input int si, input int sq, input int lc, input int ls,
                        input int es, input bit esat);
        bit ok;
        int n;
        i_sig_i = si[15:0];
        i_sig_q = sq[15:0];
        i_lo_i  = lc[15:0];
        i_lo_q  = ls[15:0];
        i_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge i_clk);
            if (o_ready) begin
                ok = 1'b1;
                exp_sig_q.push_back(es);
                exp_sat_q.push_back(esat);
            end
            @(posedge i_clk);
            #1;
            n++;
        end
        i_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_sig_q.size() != 0 && n < 200) begin
            @(posedge i_clk);
            n++;
        end
        if (exp_sig_q.size() != 0) check("drain_timeout", exp_sig_q.size(), 0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic stall_phase();
        int n;
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("bp_first_valid", o_valid, 1);
        i_ready = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            check("bp_o_ready", o_ready, 0);
            check("bp_o_valid", o_valid, 1);
            check("bp_o_signal", o_signal, -1000);
            @(posedge i_clk);
            #1;
        end
        i_ready = 1'b1;
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_sat_clr = 1'b0;
        i_sig_i   = '0;
        i_sig_q   = '0;
        i_lo_i    = '0;
        i_lo_q    = '0;

        #23;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_signal", o_signal, 0);
        check("rst_o_sat", o_sat, 0);
        check("rst_sat_count", o_sat_count, 0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        // Passthrough scaling with latency check
        send(16384, 0, 32767, 0, 16384, 0);
        @(posedge i_clk); #1;
        check("lat1_not_yet", o_valid, 0);
        @(posedge i_clk); #1;
        check("lat1_valid", o_valid, 1);
        drain();

        // Round-half-up on both signs, mixed I/Q
        send(1, 0, 16384, 0, 1, 0);
        send(-1, 0, 16384, 0, 0, 0);
        send(100, 200, 16384, 16384, -50, 0);
        // Quadrature sign
        send(0, 8192, 0, 32767, -8192, 0);
        send(0, 8192, 0, -32768, 8192, 0);
        drain();

        // Saturation and counter
        send(-32768, -32768, -32768, 32767, 32767, 1);
        drain();
        check("sat_count_1", o_sat_count, 1);
        send(-32768, -32768, 32767, -32768, -32768, 1);
        drain();
        check("sat_count_2", o_sat_count, 2);
        i_sat_clr = 1'b1;
        @(posedge i_clk); #1;
        i_sat_clr = 1'b0;
        check("sat_clr", o_sat_count, 0);

        // Backpressure: 5 samples, output held for 4 clocks
        fork
            begin
                for (int k = 1; k <= 5; k++) send(1000 * k, 0, -32768, 0, -1000 * k, 0);
            end
            stall_phase();
        join
        drain();

        // Strobe every 4th clock: latency 3 strobes = 8 clocks after accept
        ce_div = 4;
        send(1000, 0, -32768, 0, -1000, 0);
        repeat (7) begin @(posedge i_clk); #1; end
        check("ce_lat_not_yet", o_valid, 0);
        @(posedge i_clk); #1;
        check("ce_lat_valid", o_valid, 1);
        drain();
        send(3000, 0, -32768, 0, -3000, 0);
        repeat (8) begin @(posedge i_clk); #1; end
        send(-5000, 0, -32768, 0, 5000, 0);
        drain();
        ce_div = 1;
        drain();

        // Counter saturates at 65535
        for (int k = 0; k < 65537; k++) send(-32768, -32768, -32768, 32767, 32767, 1);
        drain();
        check("sat_count_max", o_sat_count, 65535);

        // Async reset with 3 samples in flight
        send(16384, 0, 32767, 0, 16384, 0);
        send(1, 0, 16384, 0, 1, 0);
        send(2000, 0, -32768, 0, -2000, 0);
        check("pre_reset_valid", o_valid, 1);
        #1;
        i_reset_n = 1'b0;
        #1;
        check("arst_o_valid", o_valid, 0);
        check("arst_o_signal", o_signal, 0);
        check("arst_sat_count", o_sat_count, 0);
        exp_sig_q.delete();
        exp_sat_q.delete();
        repeat (3) @(posedge i_clk);
        #3;
        i_reset_n = 1'b1;
        repeat (5) begin
            @(posedge i_clk); #1;
            check("post_reset_idle", o_valid, 0);
        end
        send(0, 8192, 0, 32767, -8192, 0);
        @(posedge i_clk); #1;
        check("post_reset_lat_not_yet", o_valid, 0);
        @(posedge i_clk); #1;
        check("post_reset_lat_valid", o_valid, 1);
        drain();

        check("scoreboard_empty", exp_sig_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/iq_upconv.md
# iq_upconv

Quadrature upconverter: takes complex baseband samples (I, Q) and mixes them with the quadrature LO samples produced by the `dds` block. It outputs one real, rounded and saturated sample per accepted input: `s = I·cos − Q·sin`. It sits on the transmit side of the IQ modulator, opposite the `iq_gen` downconverter. It is a 3-stage valid/ready pipeline gated by the shared `i_ce` sample strobe, and it counts saturation events.

## Interface
- `IW`, 16: baseband input and real output sample width (signed).
- `sine_lookup_width`, 16: LO sample width LW (signed, full-scale ±2^(LW−1)).
- `CW`, 16: saturation counter width.
- `i_clk`  in  1  system clock; all state on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_ce`  in  1  sample-rate clock enable; the pipeline never advances while low.
- `i_valid`  in  1  input sample valid.
- `o_ready`  out  1  input accepted this cycle when `i_valid & o_ready`.
- `i_sig_i`, `i_sig_q`  in  IW  signed baseband I and Q.
- `i_lo_i`, `i_lo_q`  in  LW  signed LO cos/sin from `dds` (`o_sample_i`/`o_sample_q`), sampled with the input.
- `o_valid`  out  1  output sample valid.
- `i_ready`  in  1  downstream ready.
- `o_signal`  out  IW  signed real output.
- `o_sat`  out  1  the sample on `o_signal` was saturated (qualified by `o_valid`).
- `i_sat_clr`  in  1  synchronous clear of `o_sat_count`.
- `o_sat_count`  out  CW  saturating count of saturated samples delivered.

## Operation
- Pipeline advance: `adv = i_ce & (~o_valid | i_ready)`.
  - `o_ready = adv`. This is combinational from `i_ce`, `i_ready` and `o_valid`, and is documented as such.
  - All stages shift together on `adv`. Each stage carries a valid bit.
- S1 (capture): on `adv`, register `i_sig_i`, `i_sig_q`, `i_lo_i`, `i_lo_q` and `v1 <= i_valid`.
- S2 (multiply): on `adv`, `p_i <= I·cos`, `p_q <= Q·sin`, each signed IW+LW bits; `v2 <= v1`.
- S3 (combine): on `adv`:
  - `d = p_i − p_q`, signed IW+LW+1 bits.
  - `r = (d + 2^(LW−2)) >>> (LW−1)`: round half up, arithmetic shift.
  - If `r > 2^(IW−1)−1`, output `2^(IW−1)−1` with `o_sat=1`. If `r < −2^(IW−1)`, output `−2^(IW−1)` with `o_sat=1`. Otherwise output `r` with `o_sat=0`.
  - `o_valid <= v2`.
- Bubbles (`i_valid=0` while `adv`) propagate as invalid stages. `o_signal` and `o_sat` hold their last values when `o_valid=0`.
- Stall: when `o_valid & ~i_ready`, `adv=0` and every stage holds. `o_signal`, `o_sat` and `o_valid` stay stable until the output is taken.
- Counter:
  - Increments when `o_valid & i_ready & i_ce & o_sat`, i.e. on delivery.
  - Saturates at 2^CW−1.
  - `i_sat_clr` has priority over increment and clears to 0.
- Reset (`i_reset_n` low, at any time including mid-stream):
  - All valid bits, `o_valid`, `o_sat`, `o_signal` and `o_sat_count` go to 0 immediately.
  - Data registers clear to 0.
  - In-flight samples are discarded.
  - After release, the first acceptance requires `i_ce=1`.

## Timing
- Latency: a sample accepted on advance k appears with `o_valid=1` after advance k+2, i.e. 3 `adv` cycles. With `i_ce` and `i_ready` tied high, throughput is 1 sample per clock and latency is 3 clocks.
- With `i_ce` pulsing every N clocks, the pipeline moves only on strobe cycles. Latency is 3 strobes.
- Nothing changes on `i_ce=0` cycles except async reset and `i_sat_clr`.
- `o_ready` is low in any cycle with `i_ce=0`, or with `o_valid=1 & i_ready=0`.
- Simultaneous accept and deliver on the same `adv` is supported with no bubble inserted.

## Test plan
- Passthrough scaling (IW=LW=16, `i_ce=i_ready=1`): I=16384, Q=0, cos=32767, sin=0 -> `o_signal=16384` (d=536854528, exact half rounded up), `o_sat=0`, 3 clocks after accept.
- Quadrature sign: I=0, Q=8192, cos=0, sin=32767 -> `o_signal=−8192`. Same with sin=−32768 -> `o_signal=8192`.
- Saturation: I=Q=−32768, cos=−32768, sin=32767 -> r=65535, `o_signal=32767`, `o_sat=1`, `o_sat_count` 0→1. Mirrored with cos=32767, sin=−32768 -> `o_signal=−32768`, count 2. Assert `i_sat_clr` -> count 0. Force 2^16 saturations -> count holds at 65535.
- Backpressure: stream of 5 samples, `i_ready` low for 4 clocks after the first output -> `o_ready=0`, output stable, no loss or duplication; all 5 outputs in order.
- `i_ce` every 4th clock: outputs appear only on strobe cycles, 3 strobes after input. `i_valid` gaps produce matching `o_valid` gaps.
- Async reset mid-stream with 3 samples in flight -> `o_valid`, `o_signal` and `o_sat_count` go to 0 without a clock edge. No stale sample emerges after release. The first new sample emerges 3 advances later.
